// File: rtl/mioc_nor3_stim_if.sv
// Handshake/bus bundle between the MIOC NOR3 stimulus/checker stage and its environment.
interface mioc_nor3_stim_if #(
  parameter int unsigned ERR_W = 4
);
  logic             start;
  logic             z;
  logic             in1;
  logic             in2;
  logic             in3;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_cnt;
  logic [2:0]       fail_vec;
  logic             fail_valid;

  modport master (
    output start, z,
    input  in1, in2, in3, busy, done, err_cnt, fail_vec, fail_valid
  );

  modport slave (
    input  start, z,
    output in1, in2, in3, busy, done, err_cnt, fail_vec, fail_valid
  );
endinterface

// File: rtl/mioc_nor3_stim.sv
// Stimulus/checker for a 3-input NOR under test: sweeps all 8 vectors, samples z, counts mismatches.
// Optional first-failure capture is enabled by defining MIOC_STIM_FAILCAP_EN.
module mioc_nor3_stim #(
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter int unsigned ERR_W         = 4
) (
  input logic             clk,
  input logic             rst,
  mioc_nor3_stim_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 65535) begin : g_bad_settle
    $error("mioc_nor3_stim: SETTLE_CYCLES must be in 3..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             z_s1_q, z_s2_q;
  logic             exp_c;
  logic             mismatch_c;

`ifdef MIOC_STIM_FAILCAP_EN
  logic [2:0]       fvec_q, fvec_d;
  logic             fvalid_q, fvalid_d;
`endif

  assign exp_c      = ~(vec_q[2] | vec_q[1] | vec_q[0]);
  assign mismatch_c = (z_s2_q != exp_c);

  // Two-flop synchronizer for the asynchronous gate output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_s1_q <= 1'b0;
      z_s2_q <= 1'b0;
    end else begin
      z_s1_q <= bus.z;
      z_s2_q <= z_s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 3'b000;
      cnt_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef MIOC_STIM_FAILCAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fvec_q   <= 3'b000;
      fvalid_q <= 1'b0;
    end else begin
      fvec_q   <= fvec_d;
      fvalid_q <= fvalid_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef MIOC_STIM_FAILCAP_EN
    fvec_d   = fvec_q;
    fvalid_d = fvalid_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_SETTLE;
          vec_d   = 3'b000;
          cnt_d   = RELOAD;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef MIOC_STIM_FAILCAP_EN
          fvec_d   = 3'b000;
          fvalid_d = 1'b0;
`endif
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        if (mismatch_c && (err_q != ERR_MAX)) begin
          err_d = err_q + ERR_W'(1);
        end
`ifdef MIOC_STIM_FAILCAP_EN
        if (mismatch_c && !fvalid_q) begin
          fvec_d   = vec_q;
          fvalid_d = 1'b1;
        end
`endif
        if (vec_q == 3'b111) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + 3'd1;
          cnt_d   = RELOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in1     = vec_q[2];
  assign bus.in2     = vec_q[1];
  assign bus.in3     = vec_q[0];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err_cnt = err_q;

`ifdef MIOC_STIM_FAILCAP_EN
  assign bus.fail_vec   = fvec_q;
  assign bus.fail_valid = fvalid_q;
`else
  assign bus.fail_vec   = 3'b000;
  assign bus.fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mioc_nor3_stim.sv
// Randomized self-checking bench for mioc_nor3_stim: two instances (ERR_W=4 and ERR_W=2) swept in lockstep.
module tb_mioc_nor3_stim;

  localparam int unsigned SC    = 3;
  localparam int unsigned PER   = SC + 1;
  localparam int unsigned LAST  = 8 * PER + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] fault_mask = 8'h00;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  mioc_nor3_stim_if #(.ERR_W(4)) bus_a ();
  mioc_nor3_stim_if #(.ERR_W(2)) bus_b ();

  logic [2:0] va, vb;
  assign va = {bus_a.in1, bus_a.in2, bus_a.in3};
  assign vb = {bus_b.in1, bus_b.in2, bus_b.in3};

  // Gate under test: ideal NOR, with selected vectors inverted by the fault mask
  assign bus_a.start = start;
  assign bus_b.start = start;
  assign bus_a.z     = ~(|va) ^ fault_mask[va];
  assign bus_b.z     = ~(|vb) ^ fault_mask[vb];

  mioc_nor3_stim #(.SETTLE_CYCLES(SC), .ERR_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  mioc_nor3_stim #(.SETTLE_CYCLES(SC), .ERR_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sat(input int c, input int w);
    return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
  endfunction

  task automatic check_state(input string tag, input int vexp, input int bexp, input int dexp,
                             input int nerr, input int fv, input int fval);
    chk({tag, ".vec_a"},   int'(va),               vexp);
    chk({tag, ".busy_a"},  int'(bus_a.busy),       bexp);
    chk({tag, ".done_a"},  int'(bus_a.done),       dexp);
    chk({tag, ".err_a"},   int'(bus_a.err_cnt),    sat(nerr, 4));
    chk({tag, ".fvec_a"},  int'(bus_a.fail_vec),   fv);
    chk({tag, ".fval_a"},  int'(bus_a.fail_valid), fval);
    chk({tag, ".vec_b"},   int'(vb),               vexp);
    chk({tag, ".busy_b"},  int'(bus_b.busy),       bexp);
    chk({tag, ".done_b"},  int'(bus_b.done),       dexp);
    chk({tag, ".err_b"},   int'(bus_b.err_cnt),    sat(nerr, 2));
    chk({tag, ".fvec_b"},  int'(bus_b.fail_vec),   fv);
    chk({tag, ".fval_b"},  int'(bus_b.fail_valid), fval);
  endtask

  // One full sweep plus one held DONE cycle; start pulses on edge 1 and optionally on poke_n
  task automatic run_sweep(input int id, input logic [7:0] mask, input int poke_n);
    int nerr, fv, fval, vexp, bexp;
    fault_mask = mask;
    for (int n = 1; n <= int'(LAST) + 1; n++) begin
      @(negedge clk);
      start = (n == 1) || (n == poke_n);
      @(posedge clk);
      #1;
      nerr = 0;
      fv   = 0;
      fval = 0;
      // Vector v is judged on edge v*PER+PER+1; vectors are visited in ascending order
      for (int v = 7; v >= 0; v--) begin
        if (mask[v] && (v * int'(PER) + int'(PER) + 1 <= n)) begin
          nerr++;
          fv   = v;
          fval = 1;
        end
      end
`ifndef MIOC_STIM_FAILCAP_EN
      fv   = 0;
      fval = 0;
`endif
      bexp = (n <= 8 * int'(PER)) ? 1 : 0;
      vexp = (bexp == 1) ? (n - 1) / int'(PER) : 7;
      check_state($sformatf("sw%0d.n%0d", id, n), vexp, bexp, 1 - bexp, nerr, fv, fval);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reset asserted during the settle phase of vector 101
  task automatic reset_mid_sweep();
    fault_mask = 8'hFE;
    for (int n = 1; n <= 5 * int'(PER) + 2; n++) begin
      @(negedge clk);
      start = (n == 1);
      @(posedge clk);
    end
    #1;
    chk("pre_rst.vec_a", int'(va), 5);
    #2;
    rst = 1'b1;
    #1;
    check_state("rst_async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("post_rst_idle", 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] m;
    int         poke;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_state("idle", 0, 0, 0, 0, 0, 0);

    run_sweep(0, 8'h00, 0);
    run_sweep(1, 8'h01, 0);
    run_sweep(2, 8'hFE, 0);
    run_sweep(3, 8'h00, 3 * int'(PER) + 2);
    run_sweep(4, 8'hFE, 3 * int'(PER) + 2);
    for (int i = 0; i < 6; i++) begin
      m    = 8'($urandom_range(0, 255));
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8 * PER)) : 0;
      run_sweep(10 + i, m, poke);
    end
    reset_mid_sweep();
    run_sweep(20, 8'($urandom_range(0, 255)), 0);
    run_sweep(21, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mioc_nor3_stim.md
Name: mioc_nor3_stim

Overview:
- Synthesizable stimulus and checker stage for the MIOC gate-test flow.
- Sits directly upstream of the 3-input NOR gate under test: drives in1/in2/in3 through every 3-bit vector.
- After each vector settles, consumes the gate output z, compares it to the ideal NOR and counts mismatches.
- Replaces file-driven pattern application for on-chip and self-checking test.

Parameters:
- SETTLE_CYCLES, 100, clocks each vector is held before z is sampled; legal range 3..65535.
- ERR_W, 4, width of the saturating mismatch counter.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- z  input  1  gate-under-test output; asynchronous to clk.
- in1  output  1  gate input, MSB of the current vector.
- in2  output  1  gate input, middle bit of the current vector.
- in3  output  1  gate input, LSB of the current vector.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start or reset.
- err_cnt  output  ERR_W  number of mismatching vectors in the last or current sweep; saturating.
- fail_vec  output  3  first failing vector; functional only with the optional feature.
- fail_valid  output  1  fail_vec holds a captured value; functional only with the optional feature.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, vec=3'b000, in1/in2/in3=0, busy=0, done=0, err_cnt=0, fail_vec=0, fail_valid=0, settle counter=0, synchronizer flops=0.
- Reset mid-sweep aborts immediately to the reset values; no partial results are retained.
- z passes through a 2-flop synchronizer; the check always uses the synchronized value.
- {in1,in2,in3} is registered and equals vec.
- Expected value: exp = ~(vec[2] | vec[1] | vec[0]).
- State IDLE / DONE: start=1 → SETTLE next cycle with vec=0, settle counter=SETTLE_CYCLES-1, err_cnt=0, fail_valid=0, done=0, busy=1.
- State SETTLE: counter decrements each cycle; at counter==0 → SAMPLE.
- State SAMPLE, one cycle:
  - If z_sync != exp, err_cnt increments, holding at 2^ERR_W-1.
  - If vec==3'b111 → DONE; busy=0 and done=1 from the next cycle.
  - Otherwise vec increments and the state returns to SETTLE with the counter reloaded to SETTLE_CYCLES-1.
- Timing: each vector occupies exactly SETTLE_CYCLES+1 clocks.
- Sweep length: done rises exactly 8*(SETTLE_CYCLES+1)+1 clocks after the start cycle.
- start while busy: ignored, with no effect on state or counters.
- start in DONE: begins a new sweep; err_cnt clears on acceptance.
- Outputs hold their last values in DONE; vec stays 3'b111.
- An illegal SETTLE_CYCLES (<3) is a parameter error reported at elaboration.

Optional Feature:
- Macro: MIOC_STIM_FAILCAP_EN.
- Defined:
  - On the first mismatching SAMPLE of a sweep, fail_vec captures vec and fail_valid is set.
  - Later mismatches do not overwrite the capture.
  - The capture clears when the next start is accepted and on reset.
- Undefined: fail_vec is tied to 3'b000, fail_valid is tied to 0, and no capture logic exists.

Test Plan:
- Ideal NOR model on z, SETTLE_CYCLES=3, start pulse:
  - vectors 000..111 appear in order, each held 4 clocks;
  - done rises 33 clocks after start;
  - err_cnt=0; fail_valid=0.
- z stuck at 0 → err_cnt=1; with MIOC_STIM_FAILCAP_EN: fail_vec=000, fail_valid=1.
- z stuck at 1 → err_cnt=7; with the macro: fail_vec=001.
- ERR_W=2, z stuck at 1 → err_cnt saturates at 3 and done still rises on schedule.
- start re-pulsed while busy at vector 011 → ignored; the sweep completes normally.
- Second start in DONE → err_cnt clears and the sweep repeats.
- rst asserted during SETTLE of vector 101 → all outputs return to their reset values asynchronously; the next start begins again at vec=000.
